// File: rtl/cr_cceip_64_sa_sweep_ctrl.sv
// Sweep sequencer for the statistics-aggregator counter bank.
// Turns regfile snap / clear-live level edges into one full pass over all
// counter indices, issuing a per-index command over a valid/ready port.
module cr_cceip_64_sa_sweep_ctrl #(
  parameter int unsigned N_CNTRS = 64,
  parameter int unsigned IDX_W   = 6,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             regs_sa_snap,
  input  logic             regs_sa_clear_live,
  input  logic             ovr_clr,
  output logic             sweep_valid,
  output logic [1:0]       sweep_op,
  output logic [IDX_W-1:0] sweep_idx,
  input  logic             sweep_ready,
  output logic             sweep_busy,
  output logic             sweep_done,
  output logic             sweep_overrun,
  output logic [CNT_W-1:0] sweep_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CNTRS - 1);

  state_e           state_q, state_d;
  logic             snap_q, snap_d;
  logic             clr_q, clr_d;
  logic [1:0]       pending_q, pending_d;
  logic [1:0]       op_q, op_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ovr_q, ovr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic snap_e;
  logic clr_e;
  logic load;
  logic ovr_set;

  // Next-state, request tracking and registered output values
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    load    = 1'b0;

    snap_d = regs_sa_snap;
    clr_d  = regs_sa_clear_live;
    snap_e = regs_sa_snap & ~snap_q;
    clr_e  = regs_sa_clear_live & ~clr_q;

    case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        busy_d  = 1'b0;
        if (pending_q != 2'b00) begin
          load    = 1'b1;
          op_d    = pending_q;
          idx_d   = '0;
          valid_d = 1'b1;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        // Command is held until accepted; valid never drops mid-sweep
        if (sweep_ready) begin
          if (idx_q == LAST_IDX) begin
            valid_d = 1'b0;
            done_d  = 1'b1;
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = DONE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      DONE: begin
        valid_d = 1'b0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        valid_d = 1'b0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase

    // Edges landing in the load cycle survive for the following sweep
    pending_d = (pending_q & ~{load, load}) | {clr_e, snap_e};

    // A repeated request merges into the pending one and is flagged; set beats clear
    ovr_set = (snap_e & pending_q[0] & ~load) | (clr_e & pending_q[1] & ~load);
    ovr_d   = ovr_set | (ovr_q & ~ovr_clr);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      snap_q    <= 1'b0;
      clr_q     <= 1'b0;
      pending_q <= 2'b00;
      op_q      <= 2'b00;
      idx_q     <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ovr_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      snap_q    <= snap_d;
      clr_q     <= clr_d;
      pending_q <= pending_d;
      op_q      <= op_d;
      idx_q     <= idx_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ovr_q     <= ovr_d;
      cnt_q     <= cnt_d;
    end
  end

  assign sweep_valid   = valid_q;
  assign sweep_op      = op_q;
  assign sweep_idx     = idx_q;
  assign sweep_busy    = busy_q;
  assign sweep_done    = done_q;
  assign sweep_overrun = ovr_q;
  assign sweep_cnt     = cnt_q;

endmodule

// File: tb/tb_cr_cceip_64_sa_sweep_ctrl.sv
// Directed bench for the SA sweep sequencer.
module tb_cr_cceip_64_sa_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        regs_sa_snap;
  logic        regs_sa_clear_live;
  logic        ovr_clr;
  logic        sweep_valid;
  logic [1:0]  sweep_op;
  logic [5:0]  sweep_idx;
  logic        sweep_ready;
  logic        sweep_busy;
  logic        sweep_done;
  logic        sweep_overrun;
  logic [15:0] sweep_cnt;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Mid-sweep level changes, keyed on the number of handshakes completed
  int   ev_at   [6];
  logic ev_snap [6];
  logic ev_clr  [6];
  logic ev_ovr  [6];
  logic ev_rst  [6];

  cr_cceip_64_sa_sweep_ctrl #(.N_CNTRS(64), .IDX_W(6), .CNT_W(16)) dut (
    .clk                (clk),
    .rst                (rst),
    .regs_sa_snap       (regs_sa_snap),
    .regs_sa_clear_live (regs_sa_clear_live),
    .ovr_clr            (ovr_clr),
    .sweep_valid        (sweep_valid),
    .sweep_op           (sweep_op),
    .sweep_idx          (sweep_idx),
    .sweep_ready        (sweep_ready),
    .sweep_busy         (sweep_busy),
    .sweep_done         (sweep_done),
    .sweep_overrun      (sweep_overrun),
    .sweep_cnt          (sweep_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_events();
    for (int k = 0; k < 6; k++) begin
      ev_at[k]   = -1;
      ev_snap[k] = 1'b0;
      ev_clr[k]  = 1'b0;
      ev_ovr[k]  = 1'b0;
      ev_rst[k]  = 1'b0;
    end
  endtask

  task automatic set_ev(input int k, input int at, input logic s, input logic c,
                        input logic o, input logic r);
    ev_at[k]   = at;
    ev_snap[k] = s;
    ev_clr[k]  = c;
    ev_ovr[k]  = o;
    ev_rst[k]  = r;
  endtask

  task automatic do_reset();
    regs_sa_snap       = 1'b0;
    regs_sa_clear_live = 1'b0;
    ovr_clr            = 1'b0;
    sweep_ready        = 1'b1;
    rst                = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    clear_events();
  endtask

  // Follows one sweep to its done pulse, checking every handshake.
  // done_cyc is the cycle of the done pulse, -1 on timeout, -2 if a reset event fired.
  task automatic run_sweep(input string tag, input logic [1:0] exp_op, input bit stall_odd,
                           output int done_cyc);
    int       n;
    bit       stalled;
    bit       seen_done;
    bit       applied [6];
    logic [5:0] hold_idx;
    logic [1:0] hold_op;
    n = 0;
    stalled = 1'b0;
    seen_done = 1'b0;
    hold_idx = '0;
    hold_op = '0;
    done_cyc = -1;
    for (int k = 0; k < 6; k++) applied[k] = 1'b0;
    for (int k = 0; k < 400 && !seen_done; k++) begin
      if (stalled) begin
        check({tag, "_stall_valid"}, 32'(sweep_valid), 32'd1);
        check({tag, "_stall_idx"}, 32'(sweep_idx), 32'(hold_idx));
        check({tag, "_stall_op"}, 32'(sweep_op), 32'(hold_op));
        stalled = 1'b0;
      end
      if (sweep_done) begin
        seen_done = 1'b1;
        done_cyc = cyc;
        check({tag, "_done_valid"}, 32'(sweep_valid), 32'd0);
        check({tag, "_done_busy"}, 32'(sweep_busy), 32'd1);
      end else begin
        for (int e = 0; e < 6; e++) begin
          if (!applied[e] && ev_at[e] >= 0 && n >= ev_at[e]) begin
            applied[e] = 1'b1;
            regs_sa_snap       = ev_snap[e];
            regs_sa_clear_live = ev_clr[e];
            ovr_clr            = ev_ovr[e];
            if (ev_rst[e]) begin
              rst = 1'b1;
              sweep_ready = 1'b1;
              done_cyc = -2;
              return;
            end
          end
        end
        if (n > 0)
          check({tag, "_valid_held"}, 32'(sweep_valid), 32'd1);
        sweep_ready = stall_odd ? (cyc % 2 == 0) : 1'b1;
        if (sweep_valid) begin
          if (sweep_ready) begin
            check({tag, "_idx"}, 32'(sweep_idx), 32'(n));
            check({tag, "_op"}, 32'(sweep_op), 32'(exp_op));
            n++;
          end else begin
            stalled = 1'b1;
            hold_idx = sweep_idx;
            hold_op = sweep_op;
          end
        end
        tick();
      end
    end
    sweep_ready = 1'b1;
    check({tag, "_handshakes"}, 32'(n), 32'd64);
    check({tag, "_done_seen"}, 32'(seen_done), 32'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete (checks %0d)", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c0;
    int d;
    rst = 1'b1;
    clear_events();
    do_reset();

    // Reset values
    check("rst_valid", 32'(sweep_valid), 32'd0);
    check("rst_op", 32'(sweep_op), 32'd0);
    check("rst_idx", 32'(sweep_idx), 32'd0);
    check("rst_busy", 32'(sweep_busy), 32'd0);
    check("rst_done", 32'(sweep_done), 32'd0);
    check("rst_ovr", 32'(sweep_overrun), 32'd0);
    check("rst_cnt", 32'(sweep_cnt), 32'd0);

    // 1. Snap only: latency, order, done timing
    c0 = cyc;
    regs_sa_snap = 1'b1;
    tick();
    check("t1_p1_valid", 32'(sweep_valid), 32'd0);
    check("t1_p1_busy", 32'(sweep_busy), 32'd0);
    tick();
    check("t1_p2_valid", 32'(sweep_valid), 32'd1);
    check("t1_p2_busy", 32'(sweep_busy), 32'd1);
    run_sweep("t1", 2'b01, 1'b0, d);
    check("t1_done_time", 32'(d - c0), 32'd66);
    check("t1_ovr", 32'(sweep_overrun), 32'd0);
    tick();
    check("t1_after_busy", 32'(sweep_busy), 32'd0);
    check("t1_after_done", 32'(sweep_done), 32'd0);
    check("t1_after_valid", 32'(sweep_valid), 32'd0);
    check("t1_cnt", 32'(sweep_cnt), 32'd1);

    // 2. Snap and clear together: single combined sweep
    do_reset();
    regs_sa_snap = 1'b1;
    regs_sa_clear_live = 1'b1;
    run_sweep("t2", 2'b11, 1'b0, d);
    tick();
    check("t2_cnt", 32'(sweep_cnt), 32'd1);
    tick();
    check("t2_no_second", 32'(sweep_valid), 32'd0);

    // 3. Backpressure on alternate cycles
    do_reset();
    regs_sa_snap = 1'b1;
    run_sweep("t3", 2'b01, 1'b1, d);
    tick();
    check("t3_cnt", 32'(sweep_cnt), 32'd1);

    // 4. Clear edge mid snap sweep queues a clear sweep
    do_reset();
    regs_sa_snap = 1'b1;
    set_ev(0, 20, 1'b1, 1'b1, 1'b0, 1'b0);
    run_sweep("t4a", 2'b01, 1'b0, d);
    clear_events();
    tick();
    check("t4_gap_valid", 32'(sweep_valid), 32'd0);
    check("t4_gap_busy", 32'(sweep_busy), 32'd0);
    tick();
    check("t4_b_valid", 32'(sweep_valid), 32'd1);
    run_sweep("t4b", 2'b10, 1'b0, d);
    tick();
    check("t4_cnt", 32'(sweep_cnt), 32'd2);
    check("t4_ovr", 32'(sweep_overrun), 32'd0);

    // 5. Duplicate snap edges: merge, overrun, clear, set-beats-clear
    do_reset();
    regs_sa_snap = 1'b1;
    set_ev(0, 5, 1'b0, 1'b0, 1'b0, 1'b0);
    set_ev(1, 10, 1'b1, 1'b0, 1'b0, 1'b0);
    set_ev(2, 15, 1'b0, 1'b0, 1'b0, 1'b0);
    set_ev(3, 20, 1'b1, 1'b0, 1'b0, 1'b0);
    run_sweep("t5a", 2'b01, 1'b0, d);
    check("t5_ovr_set", 32'(sweep_overrun), 32'd1);
    clear_events();
    tick();
    run_sweep("t5b", 2'b01, 1'b0, d);
    tick();
    tick();
    check("t5_idle", 32'(sweep_valid), 32'd0);
    check("t5_ovr_held", 32'(sweep_overrun), 32'd1);
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    check("t5_ovr_cleared", 32'(sweep_overrun), 32'd0);
    regs_sa_snap = 1'b0;
    tick();
    regs_sa_snap = 1'b1;
    set_ev(0, 5, 1'b0, 1'b0, 1'b0, 1'b0);
    set_ev(1, 10, 1'b1, 1'b0, 1'b0, 1'b0);
    set_ev(2, 15, 1'b0, 1'b0, 1'b0, 1'b0);
    set_ev(3, 20, 1'b1, 1'b0, 1'b1, 1'b0);
    set_ev(4, 21, 1'b1, 1'b0, 1'b0, 1'b0);
    run_sweep("t5c", 2'b01, 1'b0, d);
    check("t5_set_wins", 32'(sweep_overrun), 32'd1);
    clear_events();
    tick();
    run_sweep("t5d", 2'b01, 1'b0, d);
    tick();
    check("t5_cnt", 32'(sweep_cnt), 32'd4);

    // 6. Reset mid-sweep, snap level held across release
    do_reset();
    regs_sa_snap = 1'b1;
    set_ev(0, 30, 1'b1, 1'b0, 1'b0, 1'b1);
    run_sweep("t6a", 2'b01, 1'b0, d);
    check("t6_abort_seen", 32'(d), 32'hFFFF_FFFE);
    clear_events();
    tick();
    check("t6_rst_valid", 32'(sweep_valid), 32'd0);
    check("t6_rst_idx", 32'(sweep_idx), 32'd0);
    check("t6_rst_op", 32'(sweep_op), 32'd0);
    check("t6_rst_busy", 32'(sweep_busy), 32'd0);
    check("t6_rst_done", 32'(sweep_done), 32'd0);
    check("t6_rst_cnt", 32'(sweep_cnt), 32'd0);
    rst = 1'b0;
    tick();
    check("t6_rel1_valid", 32'(sweep_valid), 32'd0);
    check("t6_rel1_done", 32'(sweep_done), 32'd0);
    tick();
    check("t6_rel2_valid", 32'(sweep_valid), 32'd1);
    check("t6_rel2_idx", 32'(sweep_idx), 32'd0);
    check("t6_rel2_op", 32'(sweep_op), 32'd1);
    run_sweep("t6b", 2'b01, 1'b0, d);
    tick();
    check("t6_cnt", 32'(sweep_cnt), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cr_cceip_64_sa_sweep_ctrl.md
Name: cr_cceip_64_sa_sweep_ctrl

Overview:
Sequencer for the 64-entry statistics-aggregator counter bank. It converts the software-level snap and clear-live control bits into one hardware sweep over all counter indices. Each sweep issues one per-index command (snapshot, clear, or snapshot-then-clear) through a valid/ready port to the counter bank. It sits between the SA regfile outputs (regs_sa_snap, regs_sa_clear_live) and the counter bank update port, and reports busy, done and overrun status back to the regfile.

Parameters:
N_CNTRS, 64, number of counter indices swept; must be at least 2.
IDX_W, 6, width of the index; equals clog2(N_CNTRS).
CNT_W, 16, width of the completed-sweep counter.

Ports:
clk  in  1  core clock
rst  in  1  reset; synchronous, active-high
regs_sa_snap  in  1  level from regfile; rising edge requests a snapshot sweep
regs_sa_clear_live  in  1  level from regfile; rising edge requests a clear sweep
ovr_clr  in  1  single-cycle pulse; clears sweep_overrun
sweep_valid  out  1  command valid to the counter bank
sweep_op  out  2  command: 2'b01 = snap, 2'b10 = clear, 2'b11 = snap-then-clear (atomic per index)
sweep_idx  out  IDX_W  counter index for the current command
sweep_ready  in  1  counter bank accepts the command
sweep_busy  out  1  sweep in progress (state RUN or DONE)
sweep_done  out  1  one-cycle pulse at the end of a sweep
sweep_overrun  out  1  sticky; a request was lost because the same request was already pending
sweep_cnt  out  CNT_W  count of completed sweeps; wraps

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE; pending[1:0]=0; edge-detect flops=0.
  - sweep_valid=0, sweep_op=0, sweep_idx=0, sweep_busy=0, sweep_done=0, sweep_overrun=0, sweep_cnt=0.
  - An input held high across reset release counts as one rising edge in the first cycle after reset.
  - Reset mid-sweep aborts the sweep immediately. No done pulse, no cnt increment.
- Edge detect: snap_e = regs_sa_snap & ~snap_q; clr_e likewise; the _q flops are registered every cycle.
- Pending: pending_next = (pending & ~{load,load}) | {clr_e, snap_e}. "load" is the IDLE->RUN transition.
  - An edge arriving in the load cycle is kept as pending for the next sweep.
- Overrun: set when (snap_e & pending[0] & ~load) or (clr_e & pending[1] & ~load).
  - ovr_clr clears it.
  - If set and clear occur in the same cycle, set wins.
  - The duplicate request is merged, not queued.
- FSM:
  - IDLE:
    - If pending != 0: load op_q = pending, pending cleared, idx=0, go to RUN.
    - Snap and clear pending together load op 2'b11.
  - RUN:
    - sweep_valid=1; sweep_op=op_q; sweep_idx=idx.
    - On valid&ready: if idx == N_CNTRS-1, go to DONE; else idx++.
    - While valid & ~ready: op and idx are held stable. Valid is never withdrawn.
  - DONE:
    - sweep_done=1 for exactly one cycle; sweep_cnt += 1 (modulo 2^CNT_W).
    - Go to IDLE. sweep_valid=0.
- sweep_busy = (state==RUN) | (state==DONE).
- Latency: an input edge sampled at cycle t sets pending at t+1. With the FSM in IDLE at t+1, sweep_valid first asserts at t+2.
  - With ready held high: 64 valid cycles (t+2 .. t+65), done at t+66, busy t+2 .. t+66.
  - Minimum gap between back-to-back sweeps: one IDLE cycle.
- Edges arriving during RUN or DONE accumulate in pending and start the next sweep from IDLE.
- The index never wraps past N_CNTRS-1. The idx register resets to 0 on every load.

Test Plan:
1. Snap only: raise regs_sa_snap at t=10, ready=1 -> valid t=12..75, op=01, idx 0..63 in order, done pulse at t=76, sweep_cnt=1, overrun=0.
2. Snap and clear rise in the same cycle -> one sweep with op=11, 64 commands, sweep_cnt=1.
3. Backpressure: ready low on every odd cycle -> each idx is presented until accepted; op and idx stable while stalled; exactly 64 handshakes; done after idx 63 is accepted.
4. Clear edge during a snap sweep at idx 20 -> snap sweep completes; IDLE for one cycle; second sweep with op=10; sweep_cnt=2; overrun=0.
5. Two snap edges during one sweep -> second sweep op=01; sweep_overrun=1 after the second edge. ovr_clr pulse -> 0. ovr_clr coincident with a new overrun -> stays 1.
6. Reset asserted at idx 30 -> next cycle all outputs are reset values; no done pulse. A snap level still high at release -> a new sweep starts with valid at cycle 2 after release.
